ps2_scan_rx: RTL and testbench

//  PS/2 keyboard receiver with scan-code FIFO. It feeds the CPU data bus at the keyboard address and drives CPU interrupt int_[4].

---
 rtl/ps2_scan_rx_pkg.sv | 8 +
 rtl/ps2_scan_rx_if.sv | 12 +
 rtl/ps2_scan_rx_sync_fifo.sv | 34 +++
 rtl/ps2_scan_rx.sv | 94 +++++++++
 tb/tb_ps2_scan_rx.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/ps2_scan_rx_pkg.sv
// ps2_scan_rx_pkg: frame FSM states and frame-level constants shared by the PS/2 receiver
package ps2_scan_rx_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int DATA_BITS = 8;
  function automatic logic odd_ok(input logic [7:0] b, input logic p);
    return ^b ^ p;
  endfunction
endpackage

// File: rtl/ps2_scan_rx_if.sv
// ps2_scan_rx_if: CPU-side read/flag bus of the PS/2 receiver
interface ps2_scan_rx_if;
  logic read;
  logic clear;
  logic [7:0] key_out;
  logic ready;
  logic full;
  logic overflow;
  logic frame_err;
  modport master(output read, clear, input key_out, ready, full, overflow, frame_err);
  modport slave(input read, clear, output key_out, ready, full, overflow, frame_err);
endinterface

// File: rtl/ps2_scan_rx_sync_fifo.sv
// sync_fifo: show-ahead single-clock FIFO with extra pointer MSB for full/empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 keyboard frame receiver feeding a scan-code FIFO read by the CPU
module ps2_scan_rx
  import ps2_scan_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic clk_100mhz,
  input logic rst_n,
  input logic ps2_clk,
  input logic ps2_data,
  ps2_scan_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC);
  state_t st, nxt;
  logic [1:0] clk_s, dat_s, rd_s;
  logic [FW-1:0] flt_cnt;
  logic [TW-1:0] to_cnt;
  logic flt, flt_d, rd_d, fall, pop, timeout, dat;
  logic [7:0] shift, head;
  logic [2:0] bit_cnt;
  logic par, push_d, push_q, err_d, empty, fifo_full, frame_err, overflow;
  assign dat = dat_s[1];
  assign fall = flt_d & ~flt;
  assign pop = rd_s[1] & ~rd_d;
  assign timeout = (st != IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk_100mhz or negedge rst_n)
    if (!rst_n) begin
      {clk_s, dat_s, rd_s, flt, flt_d, rd_d} <= '1;
      flt_cnt <= '0;
      to_cnt <= '0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_data};
      rd_s <= {rd_s[0], bus.read};
      flt_d <= flt;
      rd_d <= rd_s[1];
      to_cnt <= (fall || st == IDLE || timeout) ? '0 : to_cnt + 1'b1;
      // a level change is only taken after FILTER_LEN consecutive disagreeing samples
      if (clk_s[1] == flt) flt_cnt <= '0;
      else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
        flt <= clk_s[1];
        flt_cnt <= '0;
      end else flt_cnt <= flt_cnt + 1'b1;
    end
  always_ff @(posedge clk_100mhz or negedge rst_n)
    if (!rst_n) st <= IDLE;
    else st <= nxt;
  always_comb begin
    nxt = st;
    if (timeout) nxt = IDLE;
    else if (fall)
      case (st)
        IDLE:    nxt = dat ? IDLE : DATA;
        DATA:    nxt = (bit_cnt == 3'(DATA_BITS - 1)) ? PARITY : DATA;
        PARITY:  nxt = STOP;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    push_d = fall && !timeout && st == STOP && dat && odd_ok(shift, par);
    err_d = timeout || (fall && ((st == IDLE && dat) || (st == STOP && !(dat && odd_ok(shift, par)))));
  end
  always_ff @(posedge clk_100mhz or negedge rst_n)
    if (!rst_n) begin
      shift <= '0;
      bit_cnt <= '0;
      par <= 1'b0;
      push_q <= 1'b0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
    end else begin
      push_q <= push_d;
      frame_err <= err_d | (frame_err & ~bus.clear);
      overflow <= (push_q & fifo_full & ~pop) | (overflow & ~bus.clear);
      if (fall && !timeout && st == IDLE) bit_cnt <= '0;
      if (fall && !timeout && st == DATA) begin
        shift <= {dat, shift[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (fall && !timeout && st == PARITY) par <= dat;
    end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk_100mhz), .rst_n(rst_n), .push(push_q), .pop(pop),
    .din(shift), .head(head), .empty(empty), .full(fifo_full)
  );
  assign bus.key_out = empty ? 8'h00 : head;
  assign bus.ready = ~empty;
  assign bus.full = fifo_full;
  assign bus.overflow = overflow;
  assign bus.frame_err = frame_err;
endmodule

// File: tb/tb_ps2_scan_rx.sv
// tb_ps2_scan_rx: randomized PS/2 frames/reads/clears against a queue-based model of the receiver
module tb_ps2_scan_rx;
  localparam int DEPTH = 8, FLT = 8, TO = 2000, HALF = 20, G = 14;
  logic clk_100mhz = 0, rst_n = 0, ps2_clk = 1, ps2_data = 1;
  ps2_scan_rx_if bus();
  ps2_scan_rx #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(FLT), .TIMEOUT_CYC(TO)) dut (
    .clk_100mhz(clk_100mhz), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .bus(bus)
  );
  always #5 clk_100mhz = ~clk_100mhz;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;
  logic [7:0] mq[$];
  bit m_ovf = 0, m_err = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk_100mhz)
    if (chk_en) begin
      chk("key_out", 32'(bus.key_out), mq.size() != 0 ? 32'(mq[0]) : 32'h0);
      chk("ready", 32'(bus.ready), 32'(mq.size() != 0));
      chk("full", 32'(bus.full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(bus.overflow), 32'(m_ovf));
      chk("frame_err", 32'(bus.frame_err), 32'(m_err));
    end
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_100mhz);
  endtask
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    if (glitch) begin
      wait_cyc(G); ps2_clk = 0; wait_cyc(3); ps2_clk = 1; wait_cyc(HALF - G - 3);
    end else wait_cyc(HALF);
    ps2_clk = 0;
    if (glitch) begin
      wait_cyc(G); ps2_clk = 1; wait_cyc(3); ps2_clk = 0; wait_cyc(HALF - G - 3);
    end else wait_cyc(HALF);
    ps2_clk = 1;
  endtask
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop, input bit glitch);
    chk_en = 0;
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(~^b ^ bad_par, glitch);
    ps2_bit(~bad_stop, glitch);
    ps2_data = 1;
    wait_cyc(HALF);
    if (bad_par || bad_stop) m_err = 1;
    else if (mq.size() < DEPTH) mq.push_back(b);
    else m_ovf = 1;
    chk_en = 1;
  endtask
  task automatic do_read(input int hold);
    chk_en = 0;
    bus.read = 1; wait_cyc(hold); bus.read = 0; wait_cyc(6);
    if (mq.size() != 0) void'(mq.pop_front());
    chk_en = 1;
  endtask
  task automatic do_clear();
    chk_en = 0;
    bus.clear = 1; wait_cyc(1); bus.clear = 0; wait_cyc(1);
    m_ovf = 0; m_err = 0;
    chk_en = 1;
  endtask
  task automatic start_err();
    chk_en = 0;
    ps2_bit(1'b1, 1'b0);
    wait_cyc(HALF);
    m_err = 1;
    chk_en = 1;
  endtask
  task automatic do_reset();
    chk_en = 0;
    rst_n = 0; wait_cyc(1);
    mq.delete(); m_ovf = 0; m_err = 0;
    chk_en = 1;
    wait_cyc(3); rst_n = 1; wait_cyc(3);
  endtask
  initial begin
    repeat (90000) @(posedge clk_100mhz);
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1);
  end
  initial begin
    bus.read = 0; bus.clear = 0;
    wait_cyc(3);
    chk("rst key_out", 32'(bus.key_out), 32'h0);
    chk("rst ready", 32'(bus.ready), 32'h0);
    chk("rst full", 32'(bus.full), 32'h0);
    chk("rst overflow", 32'(bus.overflow), 32'h0);
    chk("rst frame_err", 32'(bus.frame_err), 32'h0);
    rst_n = 1; chk_en = 1; wait_cyc(5);
    send_frame(8'h1C, 0, 0, 0);
    chk("t1 key_out", 32'(bus.key_out), 32'h1C);
    chk("t1 ready", 32'(bus.ready), 32'h1);
    chk("t1 frame_err", 32'(bus.frame_err), 32'h0);
    send_frame(8'hF0, 0, 0, 0);
    do_read(20);
    chk("t2 key_out", 32'(bus.key_out), 32'hF0);
    do_read(20);
    chk("t2 ready", 32'(bus.ready), 32'h0);
    chk("t2 empty key", 32'(bus.key_out), 32'h0);
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 0, 0, 0);
      if (i == 8) chk("t3 full", 32'(bus.full), 32'h1);
      if (i == 8) chk("t3 no ovf", 32'(bus.overflow), 32'h0);
    end
    chk("t3 ovf", 32'(bus.overflow), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      chk("t3 order", 32'(bus.key_out), 32'(i));
      do_read(int'($urandom_range(3, 30)));
    end
    chk("t3 drained", 32'(bus.ready), 32'h0);
    do_clear();
    send_frame(8'h1C, 1, 0, 0);
    chk("t4 ready", 32'(bus.ready), 32'h0);
    chk("t4 frame_err", 32'(bus.frame_err), 32'h1);
    do_clear();
    chk("t4 cleared", 32'(bus.frame_err), 32'h0);
    chk_en = 0;
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    ps2_data = 1;
    wait_cyc(TO + 10);
    m_err = 1; chk_en = 1;
    chk("t5 frame_err", 32'(bus.frame_err), 32'h1);
    do_clear();
    send_frame(8'h29, 0, 0, 0);
    chk("t5 key_out", 32'(bus.key_out), 32'h29);
    do_read(5);
    send_frame(8'h5A, 0, 0, 1);
    chk("t6 key_out", 32'(bus.key_out), 32'h5A);
    chk("t6 frame_err", 32'(bus.frame_err), 32'h0);
    for (int k = 0; k < 40; k++) begin
      int op;
      op = int'($urandom_range(0, 11));
      if (op <= 6) send_frame(8'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
      else if (op <= 9) do_read(int'($urandom_range(3, 30)));
      else if (op == 10) do_clear();
      else start_err();
    end
    do_reset();
    send_frame(8'hA5, 0, 0, 0);
    chk("post-reset key_out", 32'(bus.key_out), 32'hA5);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
